whack_a_mole_game_ctrl: RTL and testbench
=========================================

# whack_a_mole_game_ctrl

Parametrised multi-mole game controller: runs a timed game over `NUM_MOLES` holes, picks the next mole pseudo-randomly, detects hits and misses from the player buttons and keeps a saturating score. It sits between the board-level button debouncers and ms tick generator on one side and the LED/7-segment display drivers on the other. It replaces the single-mole up/down sequencer.

## Interface
- `NUM_MOLES`, 4: number of holes/buttons, 2..16.
- `MOLE_UP_MS`, 1000: ms a mole stays up if not hit, ≥1.
- `MOLE_DOWN_MS`, 1000: ms gap between moles, ≥1.
- `GAME_MS`, 20000: game length in ms, ≥1.
- `SCORE_W`, 8: score width.
- `LFSR_SEED`, 16'hACE1: LFSR reset value, non-zero.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `ms_tick`  in  1  one-`clk` pulse per millisecond.
- `start_button`  in  1  debounced level; rising edge starts a game.
- `mole_buttons`  in  `NUM_MOLES`  debounced levels, bit i = hole i.
- `mole_onehot`  out  `NUM_MOLES`  active mole; one-hot or zero.
- `game_in_progress`  out  1  high in MOLE_UP/MOLE_DOWN.
- `game_over`  out  1  high in GAMEOVER.
- `score`  out  `SCORE_W`  hits this game, saturates at all-ones.
- `time_left_ms`  out  `$clog2(GAME_MS+1)`  remaining game time.
- `hit_pulse`  out  1  one-cycle pulse per hit.
- `miss_pulse`  out  1  one-cycle pulse per miss.

## Operation
- Rising-edge detection on `start_button` and each `mole_buttons` bit: edge = input & ~previous sample. During `rst` the previous-sample registers load the current inputs, so a button held through reset gives no edge.
- 16-bit Galois LFSR (taps 16,14,13,11), steps every `clk`, reset to `LFSR_SEED`. Candidate index = LFSR[15:0] mod `NUM_MOLES`. If candidate equals the previous mole, use (candidate+1) mod `NUM_MOLES`.
- States are IDLE, MOLE_UP, MOLE_DOWN and GAMEOVER.
- IDLE: all outputs 0.
  - Start edge: load `time_left_ms`=`GAME_MS`, score=0, phase counter=`MOLE_UP_MS`, select a mole, and go to MOLE_UP.
- MOLE_UP: `mole_onehot` shows the selected mole. The phase counter decrements on `ms_tick`.
  - If the counter is 1 when a tick arrives, the mole times out. Go to MOLE_DOWN, load `MOLE_DOWN_MS`, no score change.
  - Edge on the active bit is a hit: score+1 (saturating), `hit_pulse`, go to MOLE_DOWN and load `MOLE_DOWN_MS`.
  - Edges only on inactive bits are a miss: `miss_pulse`, stay in MOLE_UP.
  - Active and inactive edges in the same cycle count as a hit only.
- MOLE_DOWN: `mole_onehot`=0. The phase counter decrements on `ms_tick`.
  - If the counter is 1 when a tick arrives, select a new mole, load `MOLE_UP_MS` and go to MOLE_UP.
  - Any button edge is a miss.
- Game timer: in MOLE_UP/MOLE_DOWN, `time_left_ms` decrements on each `ms_tick`.
  - A tick while it is 1 forces GAMEOVER at that edge. This overrides all phase transitions.
  - A hit in the same cycle is still scored.
- GAMEOVER: `game_over`=1, `mole_onehot`=0, score held, `time_left_ms`=0, button edges ignored.
  - Start edge restarts the game exactly as from IDLE.
- Start edges during MOLE_UP/MOLE_DOWN are ignored.
- `rst` in any state: IDLE, all outputs 0, LFSR=`LFSR_SEED`, counters 0. This applies mid-game too.

## Timing
- All outputs are registered and change on the edge after the triggering input sample.
- Start edge sampled at edge N: at N+1 state=MOLE_UP, `mole_onehot` valid, `game_in_progress`=1, `time_left_ms`=`GAME_MS`.
- Hit sampled at edge N: at N+1 `hit_pulse`=1, score updated, `mole_onehot`=0. Pulse width is exactly one cycle.
- A mole stays up exactly `MOLE_UP_MS` ticks; the gap is exactly `MOLE_DOWN_MS` ticks. The transition happens on the edge that samples the final tick.
- The game lasts exactly `GAME_MS` ticks from the start edge to `game_over`=1.
- No `ms_tick` while the game is running freezes all counters. Buttons still work.

## Test plan
- Bench settings for all scenarios: NUM_MOLES=4, MOLE_UP_MS=3, MOLE_DOWN_MS=2, GAME_MS=20, SCORE_W=3, `ms_tick` every 4 `clk`.
- Reset, then start edge -> next cycle `game_in_progress`=1, `time_left_ms`=20, `mole_onehot` one-hot; no buttons pressed -> `mole_onehot` alternates up for 3 ticks and down for 2, each new mole ≠ previous, `game_over`=1 exactly 20 ticks after start, score=0.
- Press the active bit while up -> one-cycle `hit_pulse`, score 0→1, `mole_onehot`=0 next cycle; press an inactive bit -> `miss_pulse`, score unchanged, mole still up.
- Press active and inactive bits in the same cycle -> `hit_pulse` only, no `miss_pulse`. Score 8 hits -> score saturates at 7.
- Hit on the same cycle as the final game tick -> score incremented and `game_over`=1 together. Start edge in GAMEOVER -> score=0, `time_left_ms`=20, MOLE_UP.
- Hold `start_button` high through `rst` and release -> no game starts. Assert `rst` mid-game -> all outputs 0 next cycle; LFSR sequence repeats identically after reset.

Source files
------------

// File: rtl/whack_a_mole_game_ctrl_if.sv
// Signal bundle between the board-side input conditioning/display drivers and
// the whack-a-mole game controller.
interface whack_a_mole_game_ctrl_if #(
  parameter int NUM_MOLES = 4,
  parameter int SCORE_W   = 8,
  parameter int TIME_W    = 15
);
  logic                 ms_tick;
  logic                 start_button;
  logic [NUM_MOLES-1:0] mole_buttons;
  logic [NUM_MOLES-1:0] mole_onehot;
  logic                 game_in_progress;
  logic                 game_over;
  logic [SCORE_W-1:0]   score;
  logic [TIME_W-1:0]    time_left_ms;
  logic                 hit_pulse;
  logic                 miss_pulse;

  modport master (
    output ms_tick, start_button, mole_buttons,
    input  mole_onehot, game_in_progress, game_over, score, time_left_ms,
           hit_pulse, miss_pulse
  );

  modport slave (
    input  ms_tick, start_button, mole_buttons,
    output mole_onehot, game_in_progress, game_over, score, time_left_ms,
           hit_pulse, miss_pulse
  );
endinterface

// File: rtl/whack_a_mole_game_ctrl.sv
// Timed multi-mole game controller: pseudo-random mole selection, hit/miss
// detection on button rising edges, saturating score and game countdown.
module whack_a_mole_game_ctrl #(
  parameter int          NUM_MOLES    = 4,
  parameter int          MOLE_UP_MS   = 1000,
  parameter int          MOLE_DOWN_MS = 1000,
  parameter int          GAME_MS      = 20000,
  parameter int          SCORE_W      = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input logic                       clk,
  input logic                       rst,
  whack_a_mole_game_ctrl_if.slave   bus
);

  localparam int IDX_W  = (NUM_MOLES > 1) ? $clog2(NUM_MOLES) : 1;
  localparam int TIME_W = $clog2(GAME_MS + 1);
  localparam int PH_MAX = (MOLE_UP_MS > MOLE_DOWN_MS) ? MOLE_UP_MS : MOLE_DOWN_MS;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOLE_UP   = 2'd1,
    MOLE_DOWN = 2'd2,
    GAMEOVER  = 2'd3
  } state_t;

  state_t               state_r;
  logic [15:0]          lfsr_r;
  logic                 start_prev_r;
  logic [NUM_MOLES-1:0] buttons_prev_r;
  logic [IDX_W-1:0]     idx_r;
  logic [PH_W-1:0]      phase_r;
  logic [TIME_W-1:0]    time_r;
  logic [SCORE_W-1:0]   score_r;
  logic [NUM_MOLES-1:0] onehot_r;
  logic                 gip_r;
  logic                 over_r;
  logic                 hit_r;
  logic                 miss_r;

  logic                 start_edge_s;
  logic [NUM_MOLES-1:0] button_edge_s;
  logic                 hit_s;
  logic                 any_edge_s;
  logic [IDX_W-1:0]     pick_s;
  logic [NUM_MOLES-1:0] pick_onehot_s;
  logic [SCORE_W-1:0]   score_inc_s;

  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    logic [15:0] nxt;
    if (cur[0]) begin
      nxt = {1'b0, cur[15:1]} ^ LFSR_TAPS;
    end else begin
      nxt = {1'b0, cur[15:1]};
    end
    return nxt;
  endfunction

  // Candidate hole from the LFSR, bumped by one when it would repeat the last mole.
  function automatic logic [IDX_W-1:0] pick_mole(input logic [15:0] lfsr,
                                                input logic [IDX_W-1:0] prev);
    logic [15:0] cand;
    cand = lfsr % 16'(NUM_MOLES);
    if (cand[IDX_W-1:0] == prev) begin
      if (cand == 16'(NUM_MOLES - 1)) begin
        cand = 16'd0;
      end else begin
        cand = cand + 16'd1;
      end
    end else begin
      cand = cand;
    end
    return cand[IDX_W-1:0];
  endfunction

  function automatic logic [NUM_MOLES-1:0] to_onehot(input logic [IDX_W-1:0] idx);
    return NUM_MOLES'(1) << idx;
  endfunction

  assign start_edge_s  = bus.start_button & ~start_prev_r;
  assign button_edge_s = bus.mole_buttons & ~buttons_prev_r;
  assign any_edge_s    = |button_edge_s;
  assign hit_s         = |(button_edge_s & onehot_r);
  assign pick_s        = pick_mole(lfsr_r, idx_r);
  assign pick_onehot_s = to_onehot(pick_s);
  assign score_inc_s   = (score_r == {SCORE_W{1'b1}}) ? score_r : score_r + SCORE_W'(1);

  // Game FSM with edge detectors, LFSR, phase/game counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      lfsr_r         <= LFSR_SEED;
      start_prev_r   <= bus.start_button;
      buttons_prev_r <= bus.mole_buttons;
      idx_r          <= '0;
      phase_r        <= '0;
      time_r         <= '0;
      score_r        <= '0;
      onehot_r       <= '0;
      gip_r          <= 1'b0;
      over_r         <= 1'b0;
      hit_r          <= 1'b0;
      miss_r         <= 1'b0;
    end else begin
      lfsr_r         <= lfsr_step(lfsr_r);
      start_prev_r   <= bus.start_button;
      buttons_prev_r <= bus.mole_buttons;
      hit_r          <= 1'b0;
      miss_r         <= 1'b0;

      case (state_r)
        IDLE, GAMEOVER: begin
          if (start_edge_s) begin
            state_r  <= MOLE_UP;
            time_r   <= TIME_W'(GAME_MS);
            score_r  <= '0;
            phase_r  <= PH_W'(MOLE_UP_MS);
            idx_r    <= pick_s;
            onehot_r <= pick_onehot_s;
            gip_r    <= 1'b1;
            over_r   <= 1'b0;
          end
        end
        MOLE_UP: begin
          if (hit_s) begin
            hit_r    <= 1'b1;
            score_r  <= score_inc_s;
            state_r  <= MOLE_DOWN;
            phase_r  <= PH_W'(MOLE_DOWN_MS);
            onehot_r <= '0;
          end else begin
            miss_r <= any_edge_s;
            if (bus.ms_tick) begin
              if (phase_r == PH_W'(1)) begin
                state_r  <= MOLE_DOWN;
                phase_r  <= PH_W'(MOLE_DOWN_MS);
                onehot_r <= '0;
              end else begin
                phase_r <= phase_r - PH_W'(1);
              end
            end
          end
        end
        MOLE_DOWN: begin
          miss_r <= any_edge_s;
          if (bus.ms_tick) begin
            if (phase_r == PH_W'(1)) begin
              state_r  <= MOLE_UP;
              phase_r  <= PH_W'(MOLE_UP_MS);
              idx_r    <= pick_s;
              onehot_r <= pick_onehot_s;
            end else begin
              phase_r <= phase_r - PH_W'(1);
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          onehot_r <= '0;
          gip_r    <= 1'b0;
          over_r   <= 1'b0;
        end
      endcase

      // The game countdown ending wins over any phase transition taken above.
      if ((state_r == MOLE_UP) || (state_r == MOLE_DOWN)) begin
        if (bus.ms_tick) begin
          if (time_r == TIME_W'(1)) begin
            state_r  <= GAMEOVER;
            time_r   <= '0;
            onehot_r <= '0;
            gip_r    <= 1'b0;
            over_r   <= 1'b1;
          end else begin
            time_r <= time_r - TIME_W'(1);
          end
        end
      end
    end
  end

  assign bus.mole_onehot      = onehot_r;
  assign bus.game_in_progress = gip_r;
  assign bus.game_over        = over_r;
  assign bus.score            = score_r;
  assign bus.time_left_ms     = time_r;
  assign bus.hit_pulse        = hit_r;
  assign bus.miss_pulse       = miss_r;

endmodule

// File: tb/tb_whack_a_mole_game_ctrl.sv
// Randomised bench for whack_a_mole_game_ctrl against a rule-level game model,
// plus directed scenarios with hand-computed expectations.
module tb_whack_a_mole_game_ctrl;

  localparam int NM = 4;
  localparam int UP = 3;
  localparam int DN = 2;
  localparam int GM = 20;
  localparam int SW = 3;
  localparam int TW = $clog2(GM + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  whack_a_mole_game_ctrl_if #(.NUM_MOLES(NM), .SCORE_W(SW), .TIME_W(TW)) bus ();

  whack_a_mole_game_ctrl #(
    .NUM_MOLES(NM), .MOLE_UP_MS(UP), .MOLE_DOWN_MS(DN),
    .GAME_MS(GM), .SCORE_W(SW), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // stimulus bookkeeping
  int   tick_cnt = 0;
  bit   tick_en  = 1'b1;
  bit   tick_now = 1'b0;

  // game model
  bit          m_run, m_over, m_up, m_hit, m_miss, m_pst;
  int          m_mole, m_prev, m_phase, m_time, m_score;
  logic [15:0] m_lfsr;
  logic [3:0]  m_pbtn;

  logic [3:0] last_mole = 4'd0;
  logic [3:0] prev_oh   = 4'd0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic new_mole(input logic [15:0] l);
    int cand;
    cand = int'(l % 16'd4);
    if (cand == m_prev) cand = (cand + 1) % NM;
    m_prev = cand;
    m_mole = cand;
  endtask

  task automatic model_edge(input bit st, input logic [3:0] btn, input bit tk, input bit r);
    logic [15:0] l0;
    logic [3:0]  be;
    bit          se;
    m_hit  = 1'b0;
    m_miss = 1'b0;
    if (r) begin
      m_run = 0; m_over = 0; m_up = 0; m_mole = 0; m_prev = 0;
      m_phase = 0; m_time = 0; m_score = 0; m_lfsr = 16'hACE1;
      m_pst = st; m_pbtn = btn;
      return;
    end
    se = st && !m_pst;
    be = btn & ~m_pbtn;
    m_pst = st;
    m_pbtn = btn;
    l0 = m_lfsr;
    m_lfsr = l0[0] ? ((l0 >> 1) ^ 16'hB400) : (l0 >> 1);
    if (!m_run) begin
      if (se) begin
        m_run = 1; m_over = 0; m_time = GM; m_score = 0; m_phase = UP;
        new_mole(l0);
        m_up = 1;
      end
    end else begin
      if (m_up) begin
        if (be[m_mole]) begin
          m_hit = 1'b1;
          if (m_score < 7) m_score++;
          m_up = 0;
          m_phase = DN;
        end else begin
          if (be != 4'd0) m_miss = 1'b1;
          if (tk) begin
            if (m_phase == 1) begin m_up = 0; m_phase = DN; end
            else m_phase--;
          end
        end
      end else begin
        if (be != 4'd0) m_miss = 1'b1;
        if (tk) begin
          if (m_phase == 1) begin new_mole(l0); m_up = 1; m_phase = UP; end
          else m_phase--;
        end
      end
      if (tk) begin
        if (m_time == 1) begin m_run = 0; m_over = 1; m_up = 0; m_time = 0; end
        else m_time--;
      end
    end
  endtask

  task automatic compare_all(input bit r);
    logic [3:0] one;
    logic [3:0] exp_oh;
    one = 4'b0001;
    exp_oh = (m_run && m_up) ? (one << m_mole) : 4'd0;
    chk("mole_onehot", bus.mole_onehot, exp_oh);
    chk("game_in_progress", bus.game_in_progress, m_run);
    chk("game_over", bus.game_over, m_over);
    chk("score", bus.score, m_score);
    chk("time_left_ms", bus.time_left_ms, m_time);
    chk("hit_pulse", bus.hit_pulse, m_hit);
    chk("miss_pulse", bus.miss_pulse, m_miss);
    if (r) begin
      last_mole = 4'd0;
    end else if (bus.mole_onehot != 4'd0 && prev_oh == 4'd0) begin
      if (last_mole != 4'd0) chk("new_mole_differs", bus.mole_onehot != last_mole, 1);
      last_mole = bus.mole_onehot;
    end
    prev_oh = bus.mole_onehot;
  endtask

  // Apply inputs for the next edge, advance the model at that edge, compare 1 time unit later.
  task automatic step(input bit st, input logic [3:0] btn, input bit r);
    rst = r;
    bus.start_button = st;
    bus.mole_buttons = btn;
    tick_now = tick_en && (tick_cnt == 3);
    tick_cnt = (tick_cnt + 1) % 4;
    bus.ms_tick = tick_now;
    @(posedge clk);
    model_edge(st, btn, tick_now, r);
    #1;
    compare_all(r);
  endtask

  function automatic logic [3:0] other_bit(input logic [3:0] act);
    logic [3:0] inv;
    inv = ~act;
    for (int i = 0; i < NM; i++) begin
      if (inv[i]) return inv & (4'b0001 << i);
    end
    return 4'd0;
  endfunction

  initial begin
    int nt, guard, hits;
    bit was, found, pressed, cur_st, r;
    logic [3:0] act, cur_btn;

    rst = 1'b1;
    bus.ms_tick = 1'b0;
    bus.start_button = 1'b0;
    bus.mole_buttons = 4'd0;

    // start held through reset must not start a game
    repeat (3) step(1'b1, 4'd0, 1'b1);
    repeat (4) step(1'b1, 4'd0, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    chk("held_start_no_game", bus.game_in_progress, 0);
    chk("held_start_no_over", bus.game_over, 0);

    // free-running game with no presses
    step(1'b1, 4'd0, 1'b0);
    chk("start_time", bus.time_left_ms, 20);
    chk("start_running", bus.game_in_progress, 1);
    chk("start_onehot_count", $countones(bus.mole_onehot), 1);
    nt = 0;
    guard = 0;
    while (!bus.game_over && guard < 400) begin
      was = bus.game_in_progress;
      step(1'b0, 4'd0, 1'b0);
      if (was && tick_now) nt++;
      guard++;
    end
    chk("game_length_ticks", nt, 20);
    chk("no_press_score", bus.score, 0);
    chk("over_time_zero", bus.time_left_ms, 0);

    // restart from GAMEOVER with ticks frozen, hit immediately
    tick_en = 1'b0;
    step(1'b1, 4'd0, 1'b0);
    chk("restart_score", bus.score, 0);
    chk("restart_time", bus.time_left_ms, 20);
    chk("restart_running", bus.game_in_progress, 1);
    act = bus.mole_onehot;
    step(1'b0, act, 1'b0);
    chk("hit_pulse_set", bus.hit_pulse, 1);
    chk("hit_score", bus.score, 1);
    chk("hit_mole_cleared", bus.mole_onehot, 0);
    step(1'b0, 4'd0, 1'b0);
    chk("hit_pulse_width", bus.hit_pulse, 0);
    step(1'b0, 4'b0001, 1'b0);
    chk("down_miss", bus.miss_pulse, 1);
    step(1'b0, 4'd0, 1'b0);

    // miss on an inactive bit while up
    tick_en = 1'b1;
    guard = 0;
    while (bus.mole_onehot == 4'd0 && guard < 100) begin
      step(1'b0, 4'd0, 1'b0);
      guard++;
    end
    tick_en = 1'b0;
    act = bus.mole_onehot;
    step(1'b0, other_bit(act), 1'b0);
    chk("up_miss_pulse", bus.miss_pulse, 1);
    chk("up_miss_no_hit", bus.hit_pulse, 0);
    chk("up_miss_score", bus.score, 1);
    chk("up_miss_mole_up", $countones(bus.mole_onehot), 1);
    step(1'b0, 4'd0, 1'b0);

    // hit on the final game tick
    tick_en = 1'b1;
    found = 1'b0;
    guard = 0;
    while (!found && guard < 400 && bus.game_in_progress) begin
      if (bus.mole_onehot != 4'd0 && bus.time_left_ms == 1 && tick_cnt == 3) found = 1'b1;
      else step(1'b0, 4'd0, 1'b0);
      guard++;
    end
    chk("final_hit_setup", found, 1);
    if (found) begin
      step(1'b0, bus.mole_onehot, 1'b0);
      chk("final_hit_over", bus.game_over, 1);
      chk("final_hit_pulse", bus.hit_pulse, 1);
      chk("final_hit_score", bus.score, 2);
      chk("final_hit_time", bus.time_left_ms, 0);
    end
    step(1'b0, 4'd0, 1'b0);

    // saturation; first hit pressed together with an inactive bit
    tick_en = 1'b0;
    step(1'b1, 4'd0, 1'b0);
    hits = 0;
    pressed = 1'b0;
    guard = 0;
    while (hits < 8 && guard < 600) begin
      if (bus.mole_onehot != 4'd0 && !pressed) begin
        act = bus.mole_onehot;
        if (hits == 0) act = act | other_bit(act);
        tick_en = 1'b0;
        step(1'b0, act, 1'b0);
        if (hits == 0) begin
          chk("combo_hit", bus.hit_pulse, 1);
          chk("combo_no_miss", bus.miss_pulse, 0);
        end
        hits++;
        pressed = 1'b1;
      end else begin
        tick_en = (bus.mole_onehot == 4'd0);
        step(1'b0, 4'd0, 1'b0);
        pressed = 1'b0;
      end
      guard++;
    end
    chk("saturate_hits_done", hits, 8);
    chk("saturate_score", bus.score, 7);

    // randomized play with occasional resets and tick freezes
    tick_en = 1'b1;
    cur_st = 1'b0;
    cur_btn = 4'd0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) cur_btn = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) cur_st = !cur_st;
      if ($urandom_range(0, 149) == 0) tick_en = !tick_en;
      r = ($urandom_range(0, 699) == 0);
      step(cur_st, cur_btn, r);
    end
    tick_en = 1'b1;

    // reset mid-game, then replay a game from the reset LFSR state
    step(1'b0, 4'd0, 1'b0);
    step(1'b1, 4'd0, 1'b0);
    repeat (10) step(1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 1'b1);
    chk("rst_onehot", bus.mole_onehot, 0);
    chk("rst_running", bus.game_in_progress, 0);
    chk("rst_over", bus.game_over, 0);
    chk("rst_score", bus.score, 0);
    chk("rst_time", bus.time_left_ms, 0);
    step(1'b1, 4'd0, 1'b0);
    guard = 0;
    while (!bus.game_over && guard < 400) begin
      step(1'b0, 4'd0, 1'b0);
      guard++;
    end
    chk("replay_reached_over", bus.game_over, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
